gpio_ctrl: RTL and testbench

Parametrised memory-mapped GPIO peripheral that replaces the fixed 8-bit LED/switch register in the board top. It provides per-pin direction control, atomic set/clear/toggle writes, input synchronisation, and rising/falling-edge interrupt status. It sits on CPU data port b behind the board-level address decode, which asserts sel for region 4'b0001.

---
 rtl/gpio_ctrl_pkg.sv | 21 ++
 rtl/gpio_ctrl_if.sv | 16 +
 rtl/gpio_ctrl_sync.sv | 32 +++
 rtl/gpio_ctrl.sv | 106 ++++++++++
 tb/tb_gpio_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO peripheral: register offsets, bus width and
// the board region code.
package gpio_ctrl_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] MEM_GPIO = 4'b0001;

  typedef enum logic [3:0] {
    GPIO_DATA_OUT   = 4'd0,
    GPIO_DATA_IN    = 4'd1,
    GPIO_DIR        = 4'd2,
    GPIO_OUT_SET    = 4'd3,
    GPIO_OUT_CLR    = 4'd4,
    GPIO_OUT_TGL    = 4'd5,
    GPIO_RISE_EN    = 4'd6,
    GPIO_FALL_EN    = 4'd7,
    GPIO_IRQ_STATUS = 4'd8
  } gpio_reg_e;

endpackage

// File: rtl/gpio_ctrl_if.sv
// CPU-side register bus of the GPIO block (data port b behind address decode).
interface gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  import gpio_ctrl_pkg::*;

  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output sel, we, addr, din, input dout);
  modport slave  (input sel, we, addr, din, output dout);

endinterface

// File: rtl/gpio_ctrl_sync.sv
// Pin input synchroniser with a trailing prev stage for edge detection.
module gpio_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction, atomic set/clear/toggle, synchronised inputs
// and edge-triggered interrupt status with write-1-to-clear.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0]  sync, rise, fall;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic [WIDTH-1:0]  dir_q, dir_d;
  logic [WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [WIDTH-1:0]  fall_en_q, fall_en_d;
  logic [WIDTH-1:0]  status_q, status_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [WIDTH-1:0]  wdata, clr_mask;
  logic [DATA_W-1:0] rdata;
  logic              wr;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .pin_in(pin_in),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  assign wdata = bus.din[WIDTH-1:0];
  assign wr    = bus.sel & bus.we;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    clr_mask   = '0;
    rdata      = '0;

    // Read mux looks at current register values, so a same-cycle write is not visible.
    case (bus.addr)
      ADDR_W'(GPIO_DATA_OUT):   rdata = DATA_W'(data_out_q);
      ADDR_W'(GPIO_DATA_IN):    rdata = DATA_W'(sync);
      ADDR_W'(GPIO_DIR):        rdata = DATA_W'(dir_q);
      ADDR_W'(GPIO_RISE_EN):    rdata = DATA_W'(rise_en_q);
      ADDR_W'(GPIO_FALL_EN):    rdata = DATA_W'(fall_en_q);
      ADDR_W'(GPIO_IRQ_STATUS): rdata = DATA_W'(status_q);
      default:                  rdata = '0;
    endcase

    if (wr) begin
      case (bus.addr)
        ADDR_W'(GPIO_DATA_OUT):   data_out_d = wdata;
        ADDR_W'(GPIO_DIR):        dir_d      = wdata;
        ADDR_W'(GPIO_OUT_SET):    data_out_d = data_out_q | wdata;
        ADDR_W'(GPIO_OUT_CLR):    data_out_d = data_out_q & ~wdata;
        ADDR_W'(GPIO_OUT_TGL):    data_out_d = data_out_q ^ wdata;
        ADDR_W'(GPIO_RISE_EN):    rise_en_d  = wdata;
        ADDR_W'(GPIO_FALL_EN):    fall_en_d  = wdata;
        ADDR_W'(GPIO_IRQ_STATUS): clr_mask   = wdata;
        default:                  ;
      endcase
    end

    // New events are ORed in after the clear, so set beats W1C on the same bit.
    status_d = (status_q & ~clr_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    dout_d   = bus.sel ? rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      dout_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.dout = dout_q;
  assign pin_out  = data_out_q;
  assign pin_oe   = dir_q;
  assign irq      = |status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomised bench for gpio_ctrl: a 16-pin and an 8-pin instance share stimulus
// and are compared every cycle against a history-based behavioural model.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int unsigned S16 = 2;
  localparam int unsigned S8  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pins = '0;
  logic [15:0] pin_out16, pin_oe16;
  logic [7:0]  pin_out8, pin_oe8;
  logic        irq16, irq8;

  gpio_ctrl_if #(.ADDR_W(4)) bus16 ();
  gpio_ctrl_if #(.ADDR_W(4)) bus8 ();

  gpio_ctrl #(.WIDTH(16), .SYNC_STAGES(S16), .ADDR_W(4)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .pin_in(pins),
    .pin_out(pin_out16), .pin_oe(pin_oe16), .irq(irq16)
  );

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(S8), .ADDR_W(4)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .pin_in(pins[7:0]),
    .pin_out(pin_out8), .pin_oe(pin_oe8), .irq(irq8)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the 16-pin instance, index 1 the 8-pin instance.
  logic [15:0] m_do[2], m_dir[2], m_ren[2], m_fen[2], m_st[2], m_dout[2];
  logic [15:0] hist[$];
  logic [15:0] t_m, t_sy, t_pv, t_wd, t_rd, t_clr;
  int unsigned t_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_do[k] = '0; m_dir[k] = '0; m_ren[k] = '0;
        m_fen[k] = '0; m_st[k] = '0; m_dout[k] = '0;
      end
      hist.delete();
      repeat (6) hist.push_front(16'h0000);
    end else begin
      for (int k = 0; k < 2; k++) begin
        t_m  = (k == 0) ? 16'hFFFF : 16'h00FF;
        t_s  = (k == 0) ? S16 : S8;
        // hist[0] is the pin value captured at the previous edge.
        t_sy = hist[t_s-1] & t_m;
        t_pv = hist[t_s] & t_m;
        t_wd = bus16.din & t_m;
        case (bus16.addr)
          4'd0:    t_rd = m_do[k];
          4'd1:    t_rd = t_sy;
          4'd2:    t_rd = m_dir[k];
          4'd6:    t_rd = m_ren[k];
          4'd7:    t_rd = m_fen[k];
          4'd8:    t_rd = m_st[k];
          default: t_rd = '0;
        endcase
        m_dout[k] = bus16.sel ? t_rd : 16'h0000;
        t_clr = (bus16.sel && bus16.we && bus16.addr == 4'd8) ? t_wd : 16'h0000;
        m_st[k] = (m_st[k] & ~t_clr) | (t_sy & ~t_pv & m_ren[k]) | (~t_sy & t_pv & m_fen[k]);
        if (bus16.sel && bus16.we) begin
          case (bus16.addr)
            4'd0: m_do[k]  = t_wd;
            4'd2: m_dir[k] = t_wd;
            4'd3: m_do[k]  = m_do[k] | t_wd;
            4'd4: m_do[k]  = m_do[k] & ~t_wd;
            4'd5: m_do[k]  = m_do[k] ^ t_wd;
            4'd6: m_ren[k] = t_wd;
            4'd7: m_fen[k] = t_wd;
            default: ;
          endcase
        end
      end
      hist.push_front(pins);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("dout16",    bus16.dout,       m_dout[0]);
      chk("pin_out16", pin_out16,        m_do[0]);
      chk("pin_oe16",  pin_oe16,         m_dir[0]);
      chk("irq16",     16'(irq16),       16'(|m_st[0]));
      chk("dout8",     bus8.dout,        m_dout[1]);
      chk("pin_out8",  16'(pin_out8),    m_do[1]);
      chk("pin_oe8",   16'(pin_oe8),     m_dir[1]);
      chk("irq8",      16'(irq8),        16'(|m_st[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic w, input logic [3:0] a, input logic [15:0] d);
    bus16.sel = s; bus16.we = w; bus16.addr = a; bus16.din = d;
    bus8.sel  = s; bus8.we  = w; bus8.addr  = a; bus8.din  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, 1'b0, a, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run = 1'b1;

    // Reset state: every offset reads zero.
    chk("rst_irq16", 16'(irq16), 16'h0000);
    chk("rst_oe16", pin_oe16, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("rst_read16", bus16.dout, 16'h0000);
    end

    // Output register operations.
    wr(4'd2, 16'h00FF);
    chk("dir16", pin_oe16, 16'h00FF);
    wr(4'd0, 16'h00A5);
    chk("out_a5", pin_out16, 16'h00A5);
    wr(4'd3, 16'h0002);
    chk("out_set", pin_out16, 16'h00A7);
    wr(4'd4, 16'h0001);
    chk("out_clr", pin_out16, 16'h00A6);
    wr(4'd5, 16'h00F0);
    chk("out_tgl", pin_out16, 16'h0056);
    chk("out_tgl8", 16'(pin_out8), 16'h0056);
    chk("model_do", m_do[0], 16'h0056);
    rd(4'd0);
    chk("rd_out", bus16.dout, 16'h0056);

    // Width masking and input latency.
    wr(4'd0, 16'hFFFF);
    rd(4'd0);
    chk("rd_w16", bus16.dout, 16'hFFFF);
    chk("rd_w8", bus8.dout, 16'h00FF);
    pins = 16'h003C;
    drive(1'b1, 1'b0, 4'd1, 16'h0000);
    tick(); tick();
    chk("din16_early", bus16.dout, 16'h0000);
    tick();
    chk("din16", bus16.dout, 16'h003C);
    chk("din8_early", bus8.dout, 16'h0000);
    tick();
    chk("din8", bus8.dout, 16'h003C);
    chk("model_din8", m_dout[1], 16'h003C);
    drive(1'b0, 1'b0, 4'd0, 16'h0000);

    // Edge interrupts.
    pins = 16'h0002;
    repeat (6) tick();
    wr(4'd6, 16'h0001);
    wr(4'd7, 16'h0002);
    pins = 16'h0001;
    tick(); tick();
    chk("irq16_early", 16'(irq16), 16'h0000);
    tick();
    chk("irq16_set", 16'(irq16), 16'h0001);
    chk("irq8_early", 16'(irq8), 16'h0000);
    tick();
    chk("irq8_set", 16'(irq8), 16'h0001);
    rd(4'd8);
    chk("st16", bus16.dout, 16'h0003);
    chk("st8", bus8.dout, 16'h0003);
    chk("model_st", m_st[0], 16'h0003);
    wr(4'd8, 16'h0001);
    chk("irq_after_w1c0", 16'(irq16), 16'h0001);
    rd(4'd8);
    chk("st_after_w1c0", bus16.dout, 16'h0002);
    wr(4'd8, 16'h0002);
    chk("irq16_clear", 16'(irq16), 16'h0000);
    chk("irq8_clear", 16'(irq8), 16'h0000);

    // Set wins over a coincident W1C.
    pins = 16'h0000;
    repeat (6) tick();
    pins = 16'h0001;
    repeat (6) tick();
    pins = 16'h0000;
    repeat (6) tick();
    pins = 16'h0001;
    tick(); tick();
    wr(4'd8, 16'h0001);
    chk("set_wins_irq", 16'(irq16), 16'h0001);
    rd(4'd8);
    chk("set_wins_st", bus16.dout, 16'h0001);

    // Writes with sel low are ignored.
    drive(1'b0, 1'b1, 4'd0, 16'h1234);
    tick();
    drive(1'b0, 1'b1, 4'd8, 16'hFFFF);
    tick();
    chk("nosel_irq", 16'(irq16), 16'h0001);
    rd(4'd0);
    chk("nosel_out", bus16.dout, 16'hFFFF);

    // Reset during a write.
    drive(1'b1, 1'b1, 4'd0, 16'h1234);
    #2 reset = 1'b0;
    #1;
    chk("rst_now16", pin_out16, 16'h0000);
    chk("rst_now8", 16'(pin_out8), 16'h0000);
    chk("rst_now_irq", 16'(irq16), 16'h0000);
    tick(); tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    chk("rst_after_out", pin_out16, 16'h0000);
    rd(4'd6);
    chk("rst_ren", bus16.dout, 16'h0000);
    rd(4'd7);
    chk("rst_fen", bus16.dout, 16'h0000);
    rd(4'd8);
    chk("rst_st", bus16.dout, 16'h0000);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) pins = 16'($urandom);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000);
    tick();

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
